// File: rtl/conv_window_ctrl_pkg.sv
// conv_pkg: shared constants and helpers for the 3x3 convolution window
// controller.
//   PIX_W      - bits per pixel
//   WIN_K      - window edge length (3x3)
//   WIN_DATA_W - packed window width (WIN_K*WIN_K*PIX_W)
//   win_idx()  - pixel slot in the packed window, row-major, row 0 oldest
package conv_pkg;
  localparam int PIX_W      = 8;
  localparam int WIN_K      = 3;
  localparam int WIN_DATA_W = WIN_K * WIN_K * PIX_W;

  function automatic int win_idx(input int r, input int c);
    return WIN_K * r + c;
  endfunction
endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: pixel-in and window-out handshakes of the window
// controller.
//   in_valid/in_data/in_ready        - raster pixel stream (source -> ctrl)
//   win_valid/win_data/win_row/col   - 3x3 window stream (ctrl -> MAC array)
//   win_ready                        - downstream acceptance
//   win_first/win_last               - only when CONV_WIN_FLAGS_EN is defined
// Modports: master = source/sink side, slave = controller side.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready; valid and its payload stay stable until that edge.
interface conv_window_ctrl_if
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) ();
  logic                  in_valid;
  logic [PIX_W-1:0]      in_data;
  logic                  in_ready;
  logic                  win_valid;
  logic                  win_ready;
  logic [WIN_DATA_W-1:0] win_data;
  logic [ROW_W-1:0]      win_row;
  logic [COL_W-1:0]      win_col;
`ifdef CONV_WIN_FLAGS_EN
  logic                  win_first;
  logic                  win_last;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col, win_first, win_last
  );
  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col, win_first, win_last
  );
`else
  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col
  );
  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col
  );
`endif
endinterface

// File: rtl/conv_window_ctrl_window_shift_3x3.sv
// window_shift_3x3: nine pixel registers forming the 3x3 window.
//   clk, rst    - clock, asynchronous active-high reset
//   i_shift     - shift the window one column left and load the new column
//   i_tap0..2   - new right column, row 0 (oldest) .. row 2 (current)
//   o_win       - packed window, slot win_idx(r,c) holds row r, column c
module window_shift_3x3
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift,
  input  logic [PIX_W-1:0]      i_tap0,
  input  logic [PIX_W-1:0]      i_tap1,
  input  logic [PIX_W-1:0]      i_tap2,
  output logic [WIN_DATA_W-1:0] o_win
);
  logic [PIX_W-1:0] r_pix [WIN_K][WIN_K];
  logic [PIX_W-1:0] w_tap [WIN_K];

  assign w_tap[0] = i_tap0;
  assign w_tap[1] = i_tap1;
  assign w_tap[2] = i_tap2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN_K; r++)
        for (int c = 0; c < WIN_K; c++)
          r_pix[r][c] <= '0;
    end else if (i_shift) begin
      for (int r = 0; r < WIN_K; r++) begin
        r_pix[r][0] <= r_pix[r][1];
        r_pix[r][1] <= r_pix[r][2];
        r_pix[r][2] <= w_tap[r];
      end
    end
  end

  always_comb begin
    o_win = '0;
    for (int r = 0; r < WIN_K; r++)
      for (int c = 0; c < WIN_K; c++)
        o_win[PIX_W*win_idx(r, c) +: PIX_W] = r_pix[r][c];
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences two external line buffers and a 3x3 window
// over a raster pixel stream, one window per interior pixel position.
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - synchronous frame abort (counters and pipeline flags)
//   lb_en       - enable for both line buffers (same cycle as the accept)
//   lb0_out     - line buffer 0 output (pixel one row up)
//   lb1_out     - line buffer 1 output (pixel two rows up)
//   frame_done  - one-cycle pulse after the last pixel of a frame shifts
//   bus         - pixel-in / window-out handshakes (slave modport)
// Optional: CONV_WIN_FLAGS_EN adds bus.win_first / bus.win_last.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             lb_en,
  input  logic [PIX_W-1:0] lb0_out,
  input  logic [PIX_W-1:0] lb1_out,
  output logic             frame_done,
  conv_window_ctrl_if.slave bus
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic             r_tap_vld;
  logic [PIX_W-1:0] r_cur_d;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_win_valid;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  logic             r_frame_done;

  logic w_adv, w_accept, w_shift, w_col_last, w_row_last, w_win_hit;

  // Everything moves together unless a window is stalled downstream.
  assign w_adv      = !r_win_valid || bus.win_ready;
  assign w_accept   = bus.in_valid && w_adv;
  // The window must not absorb a column during a frame abort.
  assign w_shift    = r_tap_vld && w_adv && !clear;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  // Rows 0/1 and columns 0/1 only prime the window; this also masks stale
  // line-buffer contents left from the previous frame.
  assign w_win_hit  = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  assign bus.in_ready  = w_adv;
  assign lb_en         = w_accept;
  assign bus.win_valid = r_win_valid;
  assign bus.win_row   = r_win_row;
  assign bus.win_col   = r_win_col;
  assign frame_done    = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap_vld    <= 1'b0;
      r_cur_d      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_shift && w_col_last && w_row_last;
      if (clear) begin
        r_tap_vld   <= 1'b0;
        r_row       <= '0;
        r_col       <= '0;
        r_win_valid <= 1'b0;
      end else begin
        if (w_accept) begin
          r_cur_d   <= bus.in_data;
          r_tap_vld <= 1'b1;
        end else if (w_adv) begin
          r_tap_vld <= 1'b0;
        end

        if (w_shift) begin
          r_win_valid <= w_win_hit;
          r_win_row   <= r_row - ROW_ONE;
          r_win_col   <= r_col - COL_ONE;
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + ROW_ONE;
          end else begin
            r_col <= r_col + COL_ONE;
          end
        end else if (w_adv) begin
          r_win_valid <= 1'b0;
        end
      end
    end
  end

`ifdef CONV_WIN_FLAGS_EN
  logic r_win_first, r_win_last;

  // Registered alongside win_valid so the flags describe the window on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (clear) begin
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (w_shift) begin
      r_win_first <= (r_row == ROW_TWO) && (r_col == COL_TWO);
      r_win_last  <= w_row_last && w_col_last;
    end else if (w_adv) begin
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end
  end

  assign bus.win_first = r_win_first;
  assign bus.win_last  = r_win_last;
`endif

  // Row 0 (oldest) comes from line buffer 1, row 2 is the current pixel.
  window_shift_3x3 u_win (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_tap0  (lb1_out),
    .i_tap1  (lb0_out),
    .i_tap2  (r_cur_d),
    .o_win   (bus.win_data)
  );
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed bench for conv_window_ctrl on a 4x4 image.
// Models the two external line buffers, drives raster frames and checks every
// transferred window against hand-built expectations.
module tb_conv_window_ctrl;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       lb_en;
  logic [7:0] lb0_out;
  logic [7:0] lb1_out;
  logic       frame_done;

  conv_window_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .lb_en      (lb_en),
    .lb0_out    (lb0_out),
    .lb1_out    (lb1_out),
    .frame_done (frame_done),
    .bus        (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- external line buffers ----------------
  // Registered-output delay lines: depth IMG_W and IMG_W-1, chained.
  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W-1];
  int         lb0_ptr, lb1_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lb0_out <= 8'h00;
      lb1_out <= 8'h00;
      lb0_ptr <= 0;
      lb1_ptr <= 0;
    end else if (lb_en) begin
      lb0_out          <= lb0_mem[lb0_ptr];
      lb0_mem[lb0_ptr] <= bus.in_data;
      lb0_ptr          <= (lb0_ptr == IMG_W - 1) ? 0 : lb0_ptr + 1;
      lb1_out          <= lb1_mem[lb1_ptr];
      lb1_mem[lb1_ptr] <= lb0_out;
      lb1_ptr          <= (lb1_ptr == IMG_W - 2) ? 0 : lb1_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  // Entry = {win_row[1:0], win_col[1:0], win_data[71:0]}
  logic [75:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int win_cnt  = 0;
  int fd_cnt   = 0;
  int acc10    = 0;
  bit lat_armed = 1'b0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Windows of a 4x4 frame whose pixel k has value base+k.
  task automatic push_frame(input int base);
    logic [71:0] d;
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++) begin
        d = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            d[8*(3*rr+cc) +: 8] = 8'(base + (r - 1 + rr) * IMG_W + (c - 1 + cc));
        exp_q.push_back({2'(r), 2'(c), d});
      end
  endtask

  task automatic monitor_loop();
    logic [75:0] act;
    logic [75:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.win_valid && bus.win_ready) begin
        act = {bus.win_row, bus.win_col, bus.win_data};
        if (exp_q.size() == 0) begin
          check("win_extra", 128'(exp_q.size()), 128'd1);
        end else begin
          e = exp_q.pop_front();
          check("win", act, e);
`ifdef CONV_WIN_FLAGS_EN
          check("win_first", bus.win_first, e[75:74] == 2'd1 && e[73:72] == 2'd1);
          check("win_last", bus.win_last, e[75:74] == 2'd2 && e[73:72] == 2'd2);
`endif
        end
        win_cnt++;
        if (lat_armed) begin
          check("latency", 128'(cyc - acc10), 128'd2);
          lat_armed = 1'b0;
        end
      end
      if (frame_done) fd_cnt++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [7:0] d, input int idx);
    bit got;
    got         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        if (idx == 10) acc10 = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("in_timeout", 128'd0, 128'd1);
  endtask

  task automatic send_frame(input int base, input int n);
    for (int k = 0; k < n; k++) send_pixel(8'(base + k), k);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic wait_drain(input string tag, input int n_win, input int start_cnt);
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_queue"}, 128'(exp_q.size()), 128'd0);
    check({tag, "_count"}, 128'(win_cnt - start_cnt), 128'(n_win));
  endtask

  // ---------------- test sequence ----------------
  logic [71:0] held;
  int          start;
  bit          seen;

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.win_ready = 1'b1;
    fork
      forever begin @(posedge clk); cyc++; end
      monitor_loop();
    join_none

    #3;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_lb_en", lb_en, 1'b0);
    check("rst_win_valid", bus.win_valid, 1'b0);
    check("rst_win_data", bus.win_data, 72'd0);
    check("rst_win_row", bus.win_row, 2'd0);
    check("rst_win_col", bus.win_col, 2'd0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Frame of 0..15, no backpressure, first window latency measured.
    start = win_cnt; fd_cnt = 0; lat_armed = 1'b1;
    push_frame(0);
    send_frame(0, 16);
    idle();
    wait_drain("frame_a", 4, start);
    check("frame_a_done", 128'(fd_cnt), 128'd1);

    // Backpressure: hold win_ready low for 5 cycles at the first window.
    start = win_cnt;
    push_frame(100);
    fork
      begin
        send_frame(100, 16);
        idle();
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(posedge clk);
          #1;
          if (bus.win_valid) seen = 1'b1;
        end
        check("bp_seen", seen, 1'b1);
        bus.win_ready = 1'b0;
        held = bus.win_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 1'b0);
          check("bp_lb_en", lb_en, 1'b0);
          check("bp_win_valid", bus.win_valid, 1'b1);
          check("bp_win_stable", bus.win_data, held);
        end
        @(posedge clk);
        #1 bus.win_ready = 1'b1;
      end
    join
    wait_drain("bp", 4, start);

    // Two back-to-back frames, no gap.
    start = win_cnt; fd_cnt = 0;
    push_frame(0);
    push_frame(16);
    send_frame(0, 16);
    send_frame(16, 16);
    idle();
    wait_drain("b2b", 8, start);
    check("b2b_frame_done", 128'(fd_cnt), 128'd2);

    // Abort after pixel 7, with a junk pixel offered in the clear cycle.
    start = win_cnt;
    send_frame(50, 8);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(posedge clk);
    #1;
    clear = 1'b0;
    idle();
    check("clr_win_valid", bus.win_valid, 1'b0);
    push_frame(200);
    send_frame(200, 16);
    idle();
    wait_drain("clr", 4, start);

    // Reset while a window is held on the bus.
    bus.win_ready = 1'b0;
    send_frame(0, 11);
    idle();
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      #1;
      if (bus.win_valid) seen = 1'b1;
    end
    check("rstm_seen", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstm_win_valid", bus.win_valid, 1'b0);
    check("rstm_in_ready", bus.in_ready, 1'b1);
    check("rstm_win_data", bus.win_data, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 bus.win_ready = 1'b1;
    start = win_cnt;
    push_frame(60);
    send_frame(60, 16);
    idle();
    wait_drain("rstm", 4, start);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequences two external line buffers and a 3x3 pixel window for the convolution datapath.
- Accepts a raster pixel stream with a valid/ready handshake and drives the shared line-buffer enable.
- Aligns the three row taps and emits one 3x3 window per interior pixel position, honouring downstream backpressure.
- Sits between the pixel source and the MAC array.

Parameters:
- IMG_W, 32, pixels per row; line buffer 0 depth = IMG_W, line buffer 1 depth = IMG_W-1; minimum 4.
- IMG_H, 32, rows per frame; minimum 3.
- COL_W, $clog2(IMG_W), column counter width.
- ROW_W, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. Parent drives line-buffer rstn = ~rst.
- clear  in  1  synchronous frame abort; clears counters and pipeline flags.
- in_valid  in  1  input pixel valid.
- in_data  in  8  input pixel. Also wired by the parent to line buffer 0 in_data.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- lb_en  out  1  enable to both line buffers. Line buffer 1 in_data = line buffer 0 out_data.
- lb0_out  in  8  line buffer 0 out_data.
- lb1_out  in  8  line buffer 1 out_data.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts the window.
- win_data  out  72  window; win_data[8*(3r+c)+:8] = row r, column c; r=0 is the oldest row, c=0 the leftmost column.
- win_row  out  ROW_W  centre row of the window.
- win_col  out  COL_W  centre column of the window.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is shifted.

Behaviour:
- Reset values: in_ready=1, lb_en=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0. Internal state tap_vld=0, row=0, col=0, cur_d=0.
- adv = !win_valid || win_ready.
- in_ready = adv.
- accept = in_valid && adv.
- lb_en = accept (combinational, same cycle).
- On accept, cur_d <= in_data.
- Tap alignment: in the cycle after accepting p[k], cur_d=p[k], lb0_out=p[k-W], lb1_out=p[k-2W]. The W-1 depth of line buffer 1 is what makes this hold.
- shift = tap_vld && adv.
- On shift, the window columns shift left and the new right column becomes {lb1_out, lb0_out, cur_d} for rows 0, 1, 2.
- tap_vld next state: 1 if accept; else 0 if adv; else hold.
- Counters advance on shift: col 0..IMG_W-1, wrapping to 0 and incrementing row; row wraps to 0 after IMG_H-1.
- On shift at (row, col):
  - win_valid <= (row>=2 && col>=2)
  - win_row <= row-1
  - win_col <= col-1
- If adv without a qualifying shift, win_valid <= 0.
- Backpressure: while win_valid && !win_ready, nothing moves. lb_en=0, taps and line buffers hold, and the window is stable.
- Throughput: 1 pixel/cycle while win_ready=1.
- Latency: the window appears 2 cycles after the accept of its bottom-right pixel.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No padding; the first two rows and columns produce no window.
- frame_done pulses on the shift at (IMG_H-1, IMG_W-1).
- Frame boundary: stale line-buffer contents from the previous frame are excluded by the row gating. Back-to-back frames need no gap.
- clear: row, col, tap_vld and win_valid go to 0 next cycle; an accept in the clear cycle is discarded. Line buffers are not reset; the delay is unaffected by pointer phase.
- Simultaneous clear and reset: reset dominates.
- rst mid-frame: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: CONV_WIN_FLAGS_EN.
- With the macro: ports win_first and win_last (1 bit each) are added, registered with win_valid.
  - win_first=1 for the window centred at (1,1).
  - win_last=1 for the window centred at (IMG_H-2, IMG_W-2).
- Without the macro: the ports and their logic are absent; other behaviour is identical.

Decomposition:
- Package conv_pkg holds:
  - PIX_W=8, WIN_K=3, WIN_DATA_W=72.
  - Function win_idx(r,c)=3r+c.
- Sub-module window_shift_3x3:
  - Inputs: clk, rst, shift, 3 taps.
  - Outputs: 9 pixel registers, packed per conv_pkg.
- Counters, handshake and the flag logic stay in conv_window_ctrl.

Test Plan:
- IMG_W=IMG_H=4, in_data=k for k=0..15, win_ready=1 constantly → 4 windows.
  - First window: win_data bytes 0/4/8 = 0/5/10, win_row=1, win_col=1, valid 2 cycles after the accept of p10.
  - Last window: bytes 0/8 = 5/15.
- Same frame with win_ready held 0 for 5 cycles at the first window → in_ready=0 and lb_en=0 for those cycles, win_data stable, no window lost or duplicated.
- Two back-to-back 4x4 frames → frame_done pulses exactly twice. First window of frame 2 has byte 0 = 16 (p0 of frame 2 = 16), with no stale data.
- clear asserted after pixel 7 of a frame, then a fresh frame → no window is emitted from the aborted frame, and the fresh frame produces the standard 4 windows.
- rst pulsed while win_valid=1 → win_valid=0 and in_ready=1 immediately; the next frame is correct.
- With CONV_WIN_FLAGS_EN on a 4x4 frame → win_first only on the (1,1) window, win_last only on the (2,2) window.
